// File: rtl/axivideo_pattern_src.sv
// axivideo_pattern_src: AXI-stream raster test-pattern generator, one pixel per beat.
// Framing follows OPT_TUSER_IS_SOF; OPT_SOURCE ignores TREADY like a free-running camera.
module axivideo_pattern_src #(
    parameter int PW = 24,
    parameter int LGDIM = 10,
    parameter bit OPT_TUSER_IS_SOF = 1'b1,
    parameter bit OPT_SOURCE = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic [LGDIM-1:0] i_width,
    input  logic [LGDIM-1:0] i_height,
    input  logic [1:0]       i_pattern,
    input  logic [PW-1:0]    i_color,
    output logic             M_VID_TVALID,
    input  logic             M_VID_TREADY,
    output logic [PW-1:0]    M_VID_TDATA,
    output logic             M_VID_TLAST,
    output logic             M_VID_TUSER,
    output logic [15:0]      o_frame_count
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;
    logic [LGDIM-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [15:0] cnt_q, cnt_d;
    logic valid_q, valid_d, last_q, last_d, user_q, user_d;
    logic [PW-1:0] data_q, data_d, pix;
    logic [2*LGDIM-1:0] yx;
    logic step, size_ok, hlast, vlast, n_hlast, n_vlast;

    assign step = !valid_q || M_VID_TREADY || OPT_SOURCE;
    assign size_ok = i_width > LGDIM'(2) && i_height > LGDIM'(2);
    assign hlast = x_q == w_q - LGDIM'(1);
    assign vlast = y_q == h_q - LGDIM'(1);

    // In RUN the output is always valid, so a step there means the current beat was accepted.
    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        w_d = w_q;
        h_d = h_q;
        cnt_d = cnt_q;
        if (step) begin
            if (state_q == IDLE || (hlast && vlast)) begin
                cnt_d = (state_q == RUN) ? cnt_q + 16'd1 : cnt_q;
                state_d = (i_en && size_ok) ? RUN : IDLE;
                w_d = i_width;
                h_d = i_height;
                x_d = '0;
                y_d = '0;
            end else begin
                x_d = hlast ? '0 : x_q + LGDIM'(1);
                y_d = !hlast ? y_q : (vlast ? '0 : y_q + LGDIM'(1));
            end
        end
    end

    assign yx = {y_d, x_d};
    assign n_hlast = x_d == w_d - LGDIM'(1);
    assign n_vlast = y_d == h_d - LGDIM'(1);
    assign pix = (i_pattern == 2'd0) ? {PW{x_d[4] ^ y_d[4]}} :
                 (i_pattern == 2'd1) ? PW'(yx) :
                 (i_pattern == 2'd2) ? PW'(cnt_d) : i_color;

    always_comb begin
        valid_d = valid_q;
        data_d = data_q;
        last_d = last_q;
        user_d = user_q;
        if (step) begin
            valid_d = state_d == RUN;
            data_d = valid_d ? pix : '0;
            last_d = valid_d && (OPT_TUSER_IS_SOF ? n_hlast : n_hlast && n_vlast);
            user_d = valid_d && (OPT_TUSER_IS_SOF ? (x_d == '0 && y_d == '0) : n_hlast);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            x_q <= '0;
            y_q <= '0;
            w_q <= '0;
            h_q <= '0;
            cnt_q <= '0;
            valid_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            user_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;
            y_q <= y_d;
            w_q <= w_d;
            h_q <= h_d;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            data_q <= data_d;
            last_q <= last_d;
            user_q <= user_d;
        end
    end

    assign M_VID_TVALID = valid_q;
    assign M_VID_TDATA = data_q;
    assign M_VID_TLAST = last_q;
    assign M_VID_TUSER = user_q;
    assign o_frame_count = cnt_q;
endmodule

// File: tb/tb_axivideo_pattern_src.sv
// tb_axivideo_pattern_src: directed bench for the pattern source in both framing modes and camera mode.
module tb_axivideo_pattern_src;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic [9:0] width = 10'd0, height = 10'd0;
    logic [1:0] pattern = 2'd1;
    logic [23:0] color = 24'd0;
    logic tready = 1'b1;
    logic v0, l0, u0, v1, l1, u1, v2, l2, u2;
    logic [23:0] d0, d1, d2;
    logic [15:0] c0, c1, c2;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axivideo_pattern_src dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_width(width), .i_height(height),
        .i_pattern(pattern), .i_color(color), .M_VID_TVALID(v0), .M_VID_TREADY(tready),
        .M_VID_TDATA(d0), .M_VID_TLAST(l0), .M_VID_TUSER(u0), .o_frame_count(c0));

    axivideo_pattern_src #(.OPT_TUSER_IS_SOF(1'b0)) dut_alt (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_width(width), .i_height(height),
        .i_pattern(pattern), .i_color(color), .M_VID_TVALID(v1), .M_VID_TREADY(tready),
        .M_VID_TDATA(d1), .M_VID_TLAST(l1), .M_VID_TUSER(u1), .o_frame_count(c1));

    axivideo_pattern_src #(.OPT_SOURCE(1'b1)) dut_src (
        .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_width(width), .i_height(height),
        .i_pattern(pattern), .i_color(color), .M_VID_TVALID(v2), .M_VID_TREADY(1'b0),
        .M_VID_TDATA(d2), .M_VID_TLAST(l2), .M_VID_TUSER(u2), .o_frame_count(c2));

    function automatic logic [23:0] yx(input int x, input int y);
        return 24'(y * 1024 + x);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        tready = 1'b1;
        pattern = 2'd1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start(input int w, input int h);
        width = 10'(w);
        height = 10'(h);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (v0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", v0); end
        if (d0 !== 24'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", d0); end
        if (l0 !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", l0); end
        if (u0 !== 1'b0) begin bad++; $display("FAIL reset_user got=%b exp=0", u0); end
        if (c0 !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", c0); end
    endtask

    task automatic test_basic();
        do_reset();
        start(4, 3);
        for (int b = 0; b <= 12; b++) begin
            int x = b % 4;
            int y = (b / 4) % 3;
            total += 5;
            if (v0 !== 1'b1) begin bad++; $display("FAIL basic_valid beat=%0d got=%b exp=1", b, v0); end
            if (d0 !== yx(x, y)) begin bad++; $display("FAIL basic_data beat=%0d got=%h exp=%h", b, d0, yx(x, y)); end
            if (u0 !== (b % 12 == 0)) begin bad++; $display("FAIL basic_user beat=%0d got=%b", b, u0); end
            if (l0 !== (x == 3)) begin bad++; $display("FAIL basic_last beat=%0d got=%b", b, l0); end
            if (c0 !== 16'(b / 12)) begin bad++; $display("FAIL basic_count beat=%0d got=%0d exp=%0d", b, c0, b / 12); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int acc = 0;
        int cyc = 0;
        do_reset();
        start(4, 3);
        while (acc < 24 && cyc < 200) begin
            int x = acc % 4;
            int y = (acc / 4) % 3;
            tready = pat[cyc % 4];
            total += 3;
            if (v0 !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", cyc, v0); end
            if (d0 !== yx(x, y)) begin bad++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, d0, yx(x, y)); end
            if (u0 !== (acc % 12 == 0)) begin bad++; $display("FAIL bp_user cyc=%0d got=%b", cyc, u0); end
            if (v0 && tready) acc++;
            cyc++;
            @(negedge clk);
        end
        tready = 1'b1;
        total += 2;
        if (acc != 24) begin bad++; $display("FAIL bp_timeout accepted=%0d exp=24", acc); end
        if (c0 !== 16'd2) begin bad++; $display("FAIL bp_count got=%0d exp=2", c0); end
    endtask

    task automatic test_alt_framing();
        do_reset();
        start(3, 3);
        for (int b = 0; b < 9; b++) begin
            int x = b % 3;
            total += 4;
            if (v1 !== 1'b1) begin bad++; $display("FAIL alt_valid beat=%0d got=%b exp=1", b, v1); end
            if (d1 !== yx(x, b / 3)) begin bad++; $display("FAIL alt_data beat=%0d got=%h exp=%h", b, d1, yx(x, b / 3)); end
            if (u1 !== (x == 2)) begin bad++; $display("FAIL alt_user beat=%0d got=%b", b, u1); end
            if (l1 !== (b == 8)) begin bad++; $display("FAIL alt_last beat=%0d got=%b", b, l1); end
            @(negedge clk);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        start(4, 3);
        for (int b = 0; b < 12; b++) begin
            total += 2;
            if (v0 !== 1'b1) begin bad++; $display("FAIL endrop_valid beat=%0d got=%b exp=1", b, v0); end
            if (d0 !== yx(b % 4, b / 4)) begin bad++; $display("FAIL endrop_data beat=%0d got=%h exp=%h", b, d0, yx(b % 4, b / 4)); end
            if (b == 5) en = 1'b0;
            @(negedge clk);
        end
        total += 3;
        if (v0 !== 1'b0) begin bad++; $display("FAIL endrop_idle got=%b exp=0", v0); end
        if (c0 !== 16'd1) begin bad++; $display("FAIL endrop_count got=%0d exp=1", c0); end
        repeat (3) @(negedge clk);
        if (v0 !== 1'b0) begin bad++; $display("FAIL endrop_stay_idle got=%b exp=0", v0); end
    endtask

    task automatic test_size_change();
        do_reset();
        start(4, 3);
        for (int b = 0; b < 12; b++) begin
            total += 2;
            if (d0 !== yx(b % 4, b / 4)) begin bad++; $display("FAIL size_f1_data beat=%0d got=%h exp=%h", b, d0, yx(b % 4, b / 4)); end
            if (l0 !== (b % 4 == 3)) begin bad++; $display("FAIL size_f1_last beat=%0d got=%b", b, l0); end
            if (b == 2) width = 10'd5;
            @(negedge clk);
        end
        for (int b = 0; b < 15; b++) begin
            total += 3;
            if (v0 !== 1'b1) begin bad++; $display("FAIL size_f2_valid beat=%0d got=%b exp=1", b, v0); end
            if (d0 !== yx(b % 5, b / 5)) begin bad++; $display("FAIL size_f2_data beat=%0d got=%h exp=%h", b, d0, yx(b % 5, b / 5)); end
            if (l0 !== (b % 5 == 4)) begin bad++; $display("FAIL size_f2_last beat=%0d got=%b", b, l0); end
            if (b == 3) width = 10'd2;
            @(negedge clk);
        end
        total += 3;
        if (v0 !== 1'b0) begin bad++; $display("FAIL size_idle got=%b exp=0", v0); end
        if (c0 !== 16'd2) begin bad++; $display("FAIL size_count got=%0d exp=2", c0); end
        repeat (3) @(negedge clk);
        if (v0 !== 1'b0) begin bad++; $display("FAIL size_no_beats got=%b exp=0", v0); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start(4, 3);
        repeat (18) @(negedge clk);
        total++;
        if (c0 !== 16'd1 || d0 !== yx(2, 1)) begin bad++; $display("FAIL rmid_pre count=%0d data=%h exp 1/%h", c0, d0, yx(2, 1)); end
        rst_n = 1'b0;
        @(negedge clk);
        total += 3;
        if (v0 !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", v0); end
        if (c0 !== 16'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", c0); end
        if (d0 !== 24'd0) begin bad++; $display("FAIL rmid_data got=%h exp=0", d0); end
        rst_n = 1'b1;
        @(negedge clk);
        total += 3;
        if (v0 !== 1'b1) begin bad++; $display("FAIL rmid_restart_valid got=%b exp=1", v0); end
        if (d0 !== 24'd0) begin bad++; $display("FAIL rmid_restart_data got=%h exp=0", d0); end
        if (u0 !== 1'b1) begin bad++; $display("FAIL rmid_restart_user got=%b exp=1", u0); end
    endtask

    task automatic test_source();
        do_reset();
        tready = 1'b0;
        start(4, 3);
        for (int c = 0; c <= 24; c++) begin
            total += 4;
            if (v2 !== 1'b1) begin bad++; $display("FAIL src_valid cyc=%0d got=%b exp=1", c, v2); end
            if (d2 !== yx(c % 4, (c / 4) % 3)) begin bad++; $display("FAIL src_data cyc=%0d got=%h exp=%h", c, d2, yx(c % 4, (c / 4) % 3)); end
            if (c2 !== 16'(c / 12)) begin bad++; $display("FAIL src_count cyc=%0d got=%0d exp=%0d", c, c2, c / 12); end
            if (v0 !== 1'b1 || d0 !== 24'd0) begin bad++; $display("FAIL src_stalled_peer cyc=%0d valid=%b data=%h exp 1/0", c, v0, d0); end
            @(negedge clk);
        end
        tready = 1'b1;
    endtask

    task automatic test_patterns();
        do_reset();
        pattern = 2'd0;
        color = 24'hABCDEF;
        start(20, 3);
        for (int b = 0; b < 20; b++) begin
            total++;
            if (d0 !== (b >= 16 ? 24'hFFFFFF : 24'h0)) begin bad++; $display("FAIL checker beat=%0d got=%h", b, d0); end
            if (b == 19) pattern = 2'd3;
            @(negedge clk);
        end
        total++;
        if (d0 !== 24'hABCDEF) begin bad++; $display("FAIL solid got=%h exp=abcdef", d0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_alt_framing();
        test_enable_drop();
        test_size_change();
        test_reset_mid();
        test_source();
        test_patterns();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axivideo_pattern_src.md
Name: axivideo_pattern_src

Overview:
- AXI-stream video transmitter: generates raster test-pattern frames on an M_VID_* port, one pixel per beat.
- Follows the team's video stream framing: TLAST/TUSER encode end-of-line, start-of-frame or end-of-frame, selected by OPT_TUSER_IS_SOF.
- Drives sinks and the stream checker in simulation/formal benches; also usable as an on-chip test source ahead of the frame buffer.

Parameters:
- PW, 24, pixel width in bits.
- LGDIM, 10, width of the x/y position counters and of the size inputs.
- OPT_TUSER_IS_SOF, 1, framing mode. 1: TUSER=start of frame, TLAST=end of line. 0: TLAST=end of frame, TUSER=end of line.
- OPT_SOURCE, 0, camera-style source. 1: M_VID_TREADY is ignored and every valid beat counts as accepted.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_en  in  1  enable frame generation.
- i_width  in  LGDIM  pixels per line.
- i_height  in  LGDIM  lines per frame.
- i_pattern  in  2  pattern select.
- i_color  in  PW  solid colour for pattern 3.
- M_VID_TVALID  out  1  beat valid.
- M_VID_TREADY  in  1  sink ready.
- M_VID_TDATA  out  PW  pixel.
- M_VID_TLAST  out  1  framing bit (see OPT_TUSER_IS_SOF).
- M_VID_TUSER  out  1  framing bit (see OPT_TUSER_IS_SOF).
- o_frame_count  out  16  number of completed frames.

Behaviour:
- Reset, i_reset_n=0 at a clock edge:
  - TVALID=0, TDATA=0, TLAST=0, TUSER=0.
  - o_frame_count=0, internal x=y=0, state IDLE.
  - Takes effect mid-frame too: the partial frame is abandoned and the next frame starts at x=y=0.
- Accept: acc = TVALID && (TREADY || OPT_SOURCE).
- Step: step = !TVALID || TREADY || OPT_SOURCE. Output registers load only on step.
- OPT_SOURCE=0 stability: while TVALID && !TREADY, TVALID, TDATA, TLAST and TUSER hold stable.
- States:
  - IDLE, TVALID=0. Move to RUN on step when i_en=1, i_width>2 and i_height>2. On entry, latch i_width/i_height into W/H and load pixel (0,0).
  - RUN. On every step, present the next pixel.
  - Advance rule: if x==W-1 then x<=0; else x<=x+1. On the x wrap, if y==H-1 then y<=0; else y<=y+1.
  - End of frame: when the pixel (W-1,H-1) is accepted, o_frame_count increments (wraps at 2^16).
  - At end of frame, if i_en=0 or the new size is invalid (<=2), go to IDLE with TVALID=0 on the following cycle.
  - Otherwise relatch W/H and continue with (0,0) with no bubble.
- Size changes: i_width/i_height changes mid-frame are ignored until the frame boundary.
- i_en deassert: takes effect only at a frame boundary; frames are never truncated except by reset.
- Framing, evaluated for the beat being presented:
  - hlast = x==W-1; vlast = y==H-1; sof = x==0 && y==0.
  - OPT_TUSER_IS_SOF=1: TUSER=sof, TLAST=hlast.
  - OPT_TUSER_IS_SOF=0: TLAST=hlast && vlast, TUSER=hlast.
- TDATA by i_pattern, sampled at each step:
  - 0: checkerboard, all bits = x[4]^y[4].
  - 1: {y,x} zero-extended or LSB-truncated to PW.
  - 2: o_frame_count zero-extended or truncated to PW.
  - 3: i_color.
- Latency: first TVALID appears one cycle after the edge where i_en is sampled high in IDLE.
- Throughput: one pixel per clock while TREADY=1.

Test Plan:
- Basic frame: reset, then W=4, H=3, i_en=1, TREADY=1, OPT_TUSER_IS_SOF=1, pattern 1 → 12 consecutive beats; TDATA = {y,x} in raster order; TUSER=1 only on beat 0; TLAST=1 on beats 3, 7, 11; o_frame_count=1 after beat 11; beat 12 is (0,0) again with TUSER=1.
- Backpressure: TREADY toggles in the pattern 1,0,0,1 → while stalled, TVALID and TDATA are unchanged; no pixel is skipped or repeated over 24 accepted beats; o_frame_count=2.
- Alternate framing: OPT_TUSER_IS_SOF=0, W=3, H=3 → TUSER=1 on beats 2, 5, 8; TLAST=1 only on beat 8.
- Enable drop: i_en=0 asserted at beat 5 of a 4x3 frame → frame completes through beat 11, then TVALID=0; o_frame_count=1.
- Size change: i_width changes 4→5 mid-frame → the current frame keeps 4-pixel lines; the next frame has 5-pixel lines. Setting i_width=2 → IDLE after the current frame and no beats follow.
- Reset mid-frame: reset at beat 6 → TVALID=0 next cycle; after reset release the first beat is (0,0) with TUSER=1; o_frame_count=0.
- OPT_SOURCE=1, TREADY=0 → beats still advance every clock; o_frame_count increments every W*H cycles.
